// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit core control path: opcodes, ALU functions,
// instruction field positions, control bundle and control-unit state encoding.
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;

   localparam logic [2:0] ALU_FWD = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 24;
   localparam int RD_MSB  = 18;
   localparam int RD_LSB  = 16;
   localparam int RT_MSB  = 10;
   localparam int RT_LSB  = 8;
   localparam int RS_MSB  = 2;
   localparam int RS_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   localparam int OFF_MSB = 23;
   localparam int OFF_LSB = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [2:0] aluOp;
      logic       immSel;
      logic       negSel;
      logic       branch;
      logic       jump;
      logic       regWrite;
      logic       isLoad;
      logic       isStore;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction/strobe bundle between the datapath (master) and the control unit (slave).
interface cpu_control_unit_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      INSTRUCTION;
   logic             BUSYWAIT;
   logic [2:0]       READREG1;
   logic [2:0]       READREG2;
   logic [2:0]       WRITEREG;
   logic             WRITEENABLE;
   logic [7:0]       IMMEDIATE;
   logic [2:0]       ALUOP;
   logic             IMM_SEL;
   logic             NEG_SEL;
   logic             BRANCH;
   logic             JUMP;
   logic [7:0]       BR_OFFSET;
   logic             MEM_READ;
   logic             MEM_WRITE;
   logic             PC_EN;
   logic             ILLEGAL;
   logic [CNT_W-1:0] STALL_CNT;

   modport master (
      output INSTRUCTION, BUSYWAIT,
      input  READREG1, READREG2, WRITEREG, WRITEENABLE, IMMEDIATE, ALUOP,
             IMM_SEL, NEG_SEL, BRANCH, JUMP, BR_OFFSET, MEM_READ, MEM_WRITE,
             PC_EN, ILLEGAL, STALL_CNT
   );

   modport slave (
      input  INSTRUCTION, BUSYWAIT,
      output READREG1, READREG2, WRITEREG, WRITEENABLE, IMMEDIATE, ALUOP,
             IMM_SEL, NEG_SEL, BRANCH, JUMP, BR_OFFSET, MEM_READ, MEM_WRITE,
             PC_EN, ILLEGAL, STALL_CNT
   );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode to control-bundle mapping.
// Memory opcodes are only recognised when CPU_CTRL_MEM_EN is defined.
module cpu_decoder
   import cpu_pkg::*;
(
   input  logic [7:0] opcode_i,
   output ctrl_t      ctrl_o
);

   // Anything not listed falls through to illegal and behaves as a NOP.
   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OP_LOADI: begin ctrl_o.immSel = 1'b1; ctrl_o.regWrite = 1'b1; end
         OP_MOV:   ctrl_o.regWrite = 1'b1;
         OP_ADD:   begin ctrl_o.aluOp = ALU_ADD; ctrl_o.regWrite = 1'b1; end
         OP_SUB:   begin ctrl_o.aluOp = ALU_ADD; ctrl_o.negSel = 1'b1; ctrl_o.regWrite = 1'b1; end
         OP_AND:   begin ctrl_o.aluOp = ALU_AND; ctrl_o.regWrite = 1'b1; end
         OP_OR:    begin ctrl_o.aluOp = ALU_OR;  ctrl_o.regWrite = 1'b1; end
         OP_J:     ctrl_o.jump = 1'b1;
         OP_BEQ:   begin ctrl_o.aluOp = ALU_ADD; ctrl_o.negSel = 1'b1; ctrl_o.branch = 1'b1; end
`ifdef CPU_CTRL_MEM_EN
         OP_LWD:   ctrl_o.isLoad = 1'b1;
         OP_LWI:   begin ctrl_o.isLoad = 1'b1; ctrl_o.immSel = 1'b1; end
         OP_SWD:   ctrl_o.isStore = 1'b1;
         OP_SWI:   begin ctrl_o.isStore = 1'b1; ctrl_o.immSel = 1'b1; end
`endif
         default:  ctrl_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Decode and sequencing controller: field slicing, strobes, memory-stall FSM.
// Define CPU_CTRL_MEM_EN to build load/store support, MEM_WAIT and the stall counter.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic             CLK,
   input logic             RESET,
   cpu_control_unit_if.slave bus
);

   ctrl_t            dec;
   logic             writeEnable;
   logic             memRead;
   logic             memWrite;
   logic             pcEn;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

   cpu_decoder uDecoder (
      .opcode_i (bus.INSTRUCTION[OP_MSB:OP_LSB]),
      .ctrl_o   (dec)
   );

   assign bus.READREG1  = bus.INSTRUCTION[RT_MSB:RT_LSB];
   assign bus.READREG2  = bus.INSTRUCTION[RS_MSB:RS_LSB];
   assign bus.WRITEREG  = bus.INSTRUCTION[RD_MSB:RD_LSB];
   assign bus.IMMEDIATE = bus.INSTRUCTION[IMM_MSB:IMM_LSB];
   assign bus.BR_OFFSET = bus.INSTRUCTION[OFF_MSB:OFF_LSB];
   assign bus.ALUOP     = dec.aluOp;
   assign bus.IMM_SEL   = dec.immSel;
   assign bus.NEG_SEL   = dec.negSel;
   assign bus.BRANCH    = dec.branch & ~RESET;
   assign bus.JUMP      = dec.jump & ~RESET;

`ifdef CPU_CTRL_MEM_EN
   state_t state_q, state_d;

   // The held instruction is re-decoded in MEM_WAIT; the PC cannot move until we release it.
   always_comb begin
      state_d     = state_q;
      writeEnable = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      pcEn        = 1'b0;
      stallCnt_d  = stallCnt_q;
      case (state_q)
         RUN: begin
            if (dec.isLoad || dec.isStore) begin
               memRead  = dec.isLoad;
               memWrite = dec.isStore;
               state_d  = MEM_WAIT;
            end else begin
               pcEn        = 1'b1;
               writeEnable = dec.regWrite;
            end
         end
         MEM_WAIT: begin
            if (bus.BUSYWAIT) begin
               memRead  = dec.isLoad;
               memWrite = dec.isStore;
               if (stallCnt_q != '1) stallCnt_d = stallCnt_q + CNT_W'(1);
            end else begin
               pcEn        = 1'b1;
               writeEnable = dec.isLoad;
               state_d     = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (RESET) begin
         state_d     = RUN;
         writeEnable = 1'b0;
         memRead     = 1'b0;
         memWrite    = 1'b0;
         pcEn        = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= RUN;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         stallCnt_q <= stallCnt_d;
      end
   end
`else
   always_comb begin
      writeEnable = dec.regWrite & ~RESET;
      pcEn        = ~RESET;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      stallCnt_d  = '0;
   end

   always_ff @(posedge CLK) begin
      stallCnt_q <= '0;
   end
`endif

   assign illegal_d = illegal_q | dec.illegal;

   always_ff @(posedge CLK) begin
      if (RESET) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign bus.WRITEENABLE = writeEnable;
   assign bus.MEM_READ    = memRead;
   assign bus.MEM_WRITE   = memWrite;
   assign bus.PC_EN       = pcEn;
   assign bus.ILLEGAL     = illegal_q;
   assign bus.STALL_CNT   = stallCnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit; memory scenarios run when
// CPU_CTRL_MEM_EN is defined, otherwise memory opcodes are checked as illegal.
module tb_cpu_control_unit;

   localparam int CNT_W = 16;

   logic CLK;
   logic RESET;
   int   testsRun;
   int   testsFailed;

   cpu_control_unit_if #(.CNT_W(CNT_W)) bus ();

   cpu_control_unit #(.CNT_W(CNT_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one edge and settle 1ns after it before anything is driven or sampled.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulseReset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus.INSTRUCTION = 32'h02_02_01_03;
      bus.BUSYWAIT = 1'b0;
      tick();
      tick();
      testsRun++; if (bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %0h expected 0", bus.WRITEENABLE); end
      testsRun++; if (bus.PC_EN !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pcen: got %0h expected 0", bus.PC_EN); end
      testsRun++; if (bus.STALL_CNT !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %0h expected 0", bus.STALL_CNT); end
      testsRun++; if (bus.ILLEGAL !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_illegal: got %0h expected 0", bus.ILLEGAL); end
      testsRun++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem: got %0h%0h expected 00", bus.MEM_READ, bus.MEM_WRITE); end
      RESET = 1'b0;
      #1;
      testsRun++; if (bus.WRITEENABLE !== 1'b1) begin testsFailed++; $display("[TB] FAIL add_we: got %0h expected 1", bus.WRITEENABLE); end
      testsRun++; if (bus.READREG1 !== 3'd1) begin testsFailed++; $display("[TB] FAIL add_rr1: got %0h expected 1", bus.READREG1); end
      testsRun++; if (bus.READREG2 !== 3'd3) begin testsFailed++; $display("[TB] FAIL add_rr2: got %0h expected 3", bus.READREG2); end
      testsRun++; if (bus.WRITEREG !== 3'd2) begin testsFailed++; $display("[TB] FAIL add_wr: got %0h expected 2", bus.WRITEREG); end
      testsRun++; if (bus.ALUOP !== 3'd1) begin testsFailed++; $display("[TB] FAIL add_aluop: got %0h expected 1", bus.ALUOP); end
      testsRun++; if (bus.PC_EN !== 1'b1) begin testsFailed++; $display("[TB] FAIL add_pcen: got %0h expected 1", bus.PC_EN); end
      tick();
   endtask

   task automatic test_sub_loadi();
      bus.INSTRUCTION = 32'h03_02_01_03;
      #1;
      testsRun++; if (bus.NEG_SEL !== 1'b1) begin testsFailed++; $display("[TB] FAIL sub_neg: got %0h expected 1", bus.NEG_SEL); end
      testsRun++; if (bus.ALUOP !== 3'd1) begin testsFailed++; $display("[TB] FAIL sub_aluop: got %0h expected 1", bus.ALUOP); end
      testsRun++; if (bus.IMM_SEL !== 1'b0) begin testsFailed++; $display("[TB] FAIL sub_imm: got %0h expected 0", bus.IMM_SEL); end
      tick();
      bus.INSTRUCTION = 32'h00_04_00_5F;
      #1;
      testsRun++; if (bus.IMM_SEL !== 1'b1) begin testsFailed++; $display("[TB] FAIL loadi_imm: got %0h expected 1", bus.IMM_SEL); end
      testsRun++; if (bus.IMMEDIATE !== 8'h5F) begin testsFailed++; $display("[TB] FAIL loadi_value: got %0h expected 5f", bus.IMMEDIATE); end
      testsRun++; if (bus.ALUOP !== 3'd0) begin testsFailed++; $display("[TB] FAIL loadi_aluop: got %0h expected 0", bus.ALUOP); end
      testsRun++; if (bus.WRITEENABLE !== 1'b1) begin testsFailed++; $display("[TB] FAIL loadi_we: got %0h expected 1", bus.WRITEENABLE); end
      testsRun++; if (bus.WRITEREG !== 3'd4) begin testsFailed++; $display("[TB] FAIL loadi_wr: got %0h expected 4", bus.WRITEREG); end
      testsRun++; if (bus.NEG_SEL !== 1'b0) begin testsFailed++; $display("[TB] FAIL loadi_neg: got %0h expected 0", bus.NEG_SEL); end
      tick();
   endtask

   task automatic test_logic_branch();
      bus.INSTRUCTION = 32'h04_01_02_03;
      #1;
      testsRun++; if (bus.ALUOP !== 3'd2) begin testsFailed++; $display("[TB] FAIL and_aluop: got %0h expected 2", bus.ALUOP); end
      tick();
      bus.INSTRUCTION = 32'h05_01_02_03;
      #1;
      testsRun++; if (bus.ALUOP !== 3'd3) begin testsFailed++; $display("[TB] FAIL or_aluop: got %0h expected 3", bus.ALUOP); end
      tick();
      bus.INSTRUCTION = 32'h06_F0_00_00;
      #1;
      testsRun++; if (bus.JUMP !== 1'b1) begin testsFailed++; $display("[TB] FAIL j_jump: got %0h expected 1", bus.JUMP); end
      testsRun++; if (bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL j_we: got %0h expected 0", bus.WRITEENABLE); end
      testsRun++; if (bus.BR_OFFSET !== 8'hF0) begin testsFailed++; $display("[TB] FAIL j_offset: got %0h expected f0", bus.BR_OFFSET); end
      testsRun++; if (bus.PC_EN !== 1'b1) begin testsFailed++; $display("[TB] FAIL j_pcen: got %0h expected 1", bus.PC_EN); end
      tick();
      bus.INSTRUCTION = 32'h07_08_01_02;
      #1;
      testsRun++; if (bus.BRANCH !== 1'b1 || bus.JUMP !== 1'b0) begin testsFailed++; $display("[TB] FAIL beq_branch: got %0h%0h expected 10", bus.BRANCH, bus.JUMP); end
      testsRun++; if (bus.NEG_SEL !== 1'b1 || bus.ALUOP !== 3'd1) begin testsFailed++; $display("[TB] FAIL beq_alu: got %0h/%0h expected 1/1", bus.NEG_SEL, bus.ALUOP); end
      testsRun++; if (bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL beq_we: got %0h expected 0", bus.WRITEENABLE); end
      testsRun++; if (bus.BR_OFFSET !== 8'h08) begin testsFailed++; $display("[TB] FAIL beq_offset: got %0h expected 08", bus.BR_OFFSET); end
      tick();
   endtask

`ifdef CPU_CTRL_MEM_EN
   task automatic test_load_stall();
      int wePulses;
      logic expRead, expPc;
      wePulses = 0;
      bus.INSTRUCTION = 32'h08_05_00_02;
      for (int c = 1; c <= 5; c++) begin
         bus.BUSYWAIT = (c < 5);
         #1;
         expRead = (c <= 4);
         expPc   = (c == 5);
         if (bus.WRITEENABLE === 1'b1) wePulses++;
         testsRun++; if (bus.MEM_READ !== expRead) begin testsFailed++; $display("[TB] FAIL lwd_read_c%0d: got %0h expected %0h", c, bus.MEM_READ, expRead); end
         testsRun++; if (bus.PC_EN !== expPc) begin testsFailed++; $display("[TB] FAIL lwd_pcen_c%0d: got %0h expected %0h", c, bus.PC_EN, expPc); end
         tick();
      end
      bus.INSTRUCTION = 32'h02_02_01_03;
      bus.BUSYWAIT = 1'b0;
      #1;
      testsRun++; if (wePulses != 1) begin testsFailed++; $display("[TB] FAIL lwd_we_pulses: got %0d expected 1", wePulses); end
      testsRun++; if (bus.STALL_CNT !== 16'd3) begin testsFailed++; $display("[TB] FAIL lwd_stall: got %0d expected 3", bus.STALL_CNT); end
      testsRun++; if (bus.PC_EN !== 1'b1 || bus.MEM_READ !== 1'b0) begin testsFailed++; $display("[TB] FAIL lwd_back_run: got %0h%0h expected 10", bus.PC_EN, bus.MEM_READ); end
      tick();
   endtask

   task automatic test_store_fast();
      bus.INSTRUCTION = 32'h0A_00_01_02;
      bus.BUSYWAIT = 1'b0;
      #1;
      testsRun++; if (bus.MEM_WRITE !== 1'b1 || bus.PC_EN !== 1'b0 || bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL swd_c1: got w%0h p%0h we%0h expected w1 p0 we0", bus.MEM_WRITE, bus.PC_EN, bus.WRITEENABLE); end
      tick();
      testsRun++; if (bus.MEM_WRITE !== 1'b0 || bus.PC_EN !== 1'b1 || bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL swd_c2: got w%0h p%0h we%0h expected w0 p1 we0", bus.MEM_WRITE, bus.PC_EN, bus.WRITEENABLE); end
      tick();
      bus.INSTRUCTION = 32'h02_02_01_03;
      #1;
      testsRun++; if (bus.STALL_CNT !== 16'd3) begin testsFailed++; $display("[TB] FAIL swd_stall: got %0d expected 3", bus.STALL_CNT); end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      pulseReset();
      bus.INSTRUCTION = 32'h08_05_00_02;
      bus.BUSYWAIT = 1'b1;
      tick();
      tick();
      testsRun++; if (bus.STALL_CNT !== 16'd1 || bus.MEM_READ !== 1'b1) begin testsFailed++; $display("[TB] FAIL midwait_pre: got cnt%0d rd%0h expected cnt1 rd1", bus.STALL_CNT, bus.MEM_READ); end
      RESET = 1'b1;
      #1;
      testsRun++; if (bus.WRITEENABLE !== 1'b0 || bus.MEM_READ !== 1'b0 || bus.PC_EN !== 1'b0) begin testsFailed++; $display("[TB] FAIL midwait_forced: got we%0h rd%0h p%0h expected 000", bus.WRITEENABLE, bus.MEM_READ, bus.PC_EN); end
      tick();
      RESET = 1'b0;
      bus.BUSYWAIT = 1'b0;
      #1;
      testsRun++; if (bus.WRITEENABLE !== 1'b0 || bus.MEM_READ !== 1'b1 || bus.PC_EN !== 1'b0) begin testsFailed++; $display("[TB] FAIL midwait_run: got we%0h rd%0h p%0h expected 0 1 0", bus.WRITEENABLE, bus.MEM_READ, bus.PC_EN); end
      testsRun++; if (bus.STALL_CNT !== 16'd0) begin testsFailed++; $display("[TB] FAIL midwait_stall: got %0d expected 0", bus.STALL_CNT); end
      tick();
   endtask
`else
   task automatic test_mem_disabled();
      pulseReset();
      bus.INSTRUCTION = 32'h08_05_00_02;
      bus.BUSYWAIT = 1'b1;
      #1;
      testsRun++; if (bus.MEM_READ !== 1'b0 || bus.PC_EN !== 1'b1 || bus.WRITEENABLE !== 1'b0) begin testsFailed++; $display("[TB] FAIL lwd_nop: got rd%0h p%0h we%0h expected 0 1 0", bus.MEM_READ, bus.PC_EN, bus.WRITEENABLE); end
      tick();
      testsRun++; if (bus.ILLEGAL !== 1'b1) begin testsFailed++; $display("[TB] FAIL lwd_illegal: got %0h expected 1", bus.ILLEGAL); end
      testsRun++; if (bus.STALL_CNT !== 16'd0) begin testsFailed++; $display("[TB] FAIL lwd_stall0: got %0d expected 0", bus.STALL_CNT); end
      bus.BUSYWAIT = 1'b0;
   endtask
`endif

   task automatic test_illegal();
      pulseReset();
      bus.INSTRUCTION = 32'hFF_00_00_00;
      #1;
      testsRun++; if (bus.ILLEGAL !== 1'b0) begin testsFailed++; $display("[TB] FAIL ill_before: got %0h expected 0", bus.ILLEGAL); end
      testsRun++; if (bus.WRITEENABLE !== 1'b0 || bus.PC_EN !== 1'b1) begin testsFailed++; $display("[TB] FAIL ill_nop: got we%0h p%0h expected we0 p1", bus.WRITEENABLE, bus.PC_EN); end
      tick();
      testsRun++; if (bus.ILLEGAL !== 1'b1) begin testsFailed++; $display("[TB] FAIL ill_set: got %0h expected 1", bus.ILLEGAL); end
      bus.INSTRUCTION = 32'h02_02_01_03;
      for (int c = 0; c < 2; c++) begin
         tick();
         testsRun++; if (bus.ILLEGAL !== 1'b1 || bus.WRITEENABLE !== 1'b1) begin testsFailed++; $display("[TB] FAIL ill_sticky_%0d: got ill%0h we%0h expected 1 1", c, bus.ILLEGAL, bus.WRITEENABLE); end
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      RESET = 1'b1;
      bus.INSTRUCTION = 32'h0;
      bus.BUSYWAIT = 1'b0;
      #1;
      test_reset();
      test_sub_loadi();
      test_logic_branch();
`ifdef CPU_CTRL_MEM_EN
      test_load_stall();
      test_store_fast();
      test_illegal();
      test_reset_mid_wait();
`else
      test_mem_disabled();
      test_illegal();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Decode and sequencing controller for the 8-bit single-cycle processor. It sits directly upstream of `reg_file` and the ALU. It slices the 32-bit instruction into register-file read/write addresses, the immediate and the ALU controls, and generates the register-file WRITE strobe and the PC-advance enable. A small state machine stalls the core on data-memory accesses until the memory drops BUSYWAIT, then commits load write-back.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `CLK` in 1: clock; all state updates on posedge.
- `RESET` in 1: reset, synchronous, active-high.
- `INSTRUCTION` in 32: current instruction. Fields:
  - `OP` = [31:24]
  - `RD` = [18:16]
  - `RT` = [10:8]
  - `RS` = [2:0]
  - `IMM` = [7:0]
  - `OFF` = [23:16]
- `BUSYWAIT` in 1: data memory busy.
- `READREG1` out 3: `RT` field.
- `READREG2` out 3: `RS` field.
- `WRITEREG` out 3: `RD` field.
- `WRITEENABLE` out 1: register-file WRITE.
- `IMMEDIATE` out 8: `IMM` field.
- `ALUOP` out 3: ALU function.
- `IMM_SEL` out 1: ALU operand 2 = `IMMEDIATE`.
- `NEG_SEL` out 1: ALU operand 2 is two's-complemented.
- `BRANCH` out 1: beq instruction.
- `JUMP` out 1: j instruction.
- `BR_OFFSET` out 8: `OFF` field.
- `MEM_READ` out 1: data-memory read request.
- `MEM_WRITE` out 1: data-memory write request.
- `PC_EN` out 1: PC may advance at the next edge.
- `ILLEGAL` out 1: sticky illegal-opcode flag.
- `STALL_CNT` out `CNT_W`: memory stall cycles.

## Operation
- Opcodes:
  - `00` loadi
  - `01` mov
  - `02` add
  - `03` sub
  - `04` and
  - `05` or
  - `06` j
  - `07` beq
  - `08` lwd
  - `09` lwi
  - `0A` swd
  - `0B` swi
- `ALUOP` values: FWD=0, ADD=1, AND=2, OR=3.
- Decode rules:
  - sub and beq: `ALUOP`=ADD, `NEG_SEL`=1.
  - loadi, lwi, swi: `IMM_SEL`=1.
  - Field outputs are pure slices and are always driven.
- `WRITEENABLE` is 1 only for loadi, mov, add, sub, and, or in `RUN`, and for lwd/lwi per the `MEM_WAIT` rules below. It is 0 for j, beq, swd, swi and illegal opcodes.
- States are `RUN` and `MEM_WAIT`.
- `RUN`:
  - Non-memory instruction: `PC_EN`=1, stay in `RUN`.
  - Memory instruction: assert `MEM_READ` (loads) or `MEM_WRITE` (stores), `PC_EN`=0, `WRITEENABLE`=0, go to `MEM_WAIT` at the next edge.
- `MEM_WAIT`:
  - Hold `MEM_READ`/`MEM_WRITE` while `BUSYWAIT`=1, with `PC_EN`=0 and `WRITEENABLE`=0.
  - When `BUSYWAIT`=0: `PC_EN`=1, `WRITEENABLE`=1 for loads, memory requests deasserted. Return to `RUN` at that edge.
- `STALL_CNT` increments on every edge with state=`MEM_WAIT` and `BUSYWAIT`=1. It saturates at all-ones and never wraps.
- An illegal opcode (≥`0C`):
  - sets `ILLEGAL` at the edge;
  - is treated as a NOP: `PC_EN`=1, no write, no memory request.
  - `ILLEGAL` is cleared only by `RESET`.

## Timing
- Decode outputs are combinational from `INSTRUCTION` within the same cycle (zero-cycle latency).
- Strobes (`WRITEENABLE`, `MEM_READ`, `MEM_WRITE`, `PC_EN`) are combinational from state, opcode and `BUSYWAIT`.
- A non-memory instruction completes in 1 cycle. A memory instruction takes 2 + N cycles, where N is the number of `MEM_WAIT` edges with `BUSYWAIT`=1.
- While `RESET`=1, outputs are forced regardless of state:
  - `WRITEENABLE`, `MEM_READ`, `MEM_WRITE`, `PC_EN`, `BRANCH`, `JUMP` = 0.
- At the reset edge: state←`RUN`, `ILLEGAL`←0, `STALL_CNT`←0.
- Reset during `MEM_WAIT` abandons the access: no load write-back, state `RUN`.
- Simultaneous saturation and reset: reset wins.
- `BUSYWAIT` is ignored in `RUN`.

## Configuration
- `CPU_CTRL_MEM_EN` defined:
  - Opcodes `08`–`0B` are decoded.
  - The `MEM_WAIT` state and `STALL_CNT` are built.
- `CPU_CTRL_MEM_EN` undefined:
  - Opcodes `08`–`0B` are illegal (set `ILLEGAL`).
  - `MEM_READ`/`MEM_WRITE` are tied to 0.
  - `STALL_CNT` is tied to 0.
  - The FSM reduces to `RUN` only.

## Structure
- Shared package `cpu_pkg` holds the opcode constants, `ALUOP` constants, the instruction field bit positions, and the state encoding.
- One sub-module, `cpu_decoder`: combinational opcode→control mapping.
- FSM, stall counter and `ILLEGAL` flag live in `cpu_control_unit`.

## Test plan
- Reset:
  - Stimulus: `RESET`=1 for 2 edges with `INSTRUCTION`=`02_02_01_03` (add r2,r1,r3).
  - Required: `WRITEENABLE`=0, `PC_EN`=0, `STALL_CNT`=0, `ILLEGAL`=0.
  - After release: `WRITEENABLE`=1, `READREG1`=1, `READREG2`=3, `WRITEREG`=2, `ALUOP`=1.
- sub, loadi:
  - sub → `NEG_SEL`=1, `ALUOP`=1.
  - loadi r4,#0x5F → `IMM_SEL`=1, `IMMEDIATE`=0x5F, `ALUOP`=0, `WRITEENABLE`=1.
- lwd with `BUSYWAIT` high for 3 `MEM_WAIT` edges:
  - `MEM_READ` high for 4 cycles, `PC_EN`=0 until the 5th.
  - `WRITEENABLE` pulses exactly 1 cycle.
  - `STALL_CNT`=3.
- swd with `BUSYWAIT` low immediately:
  - `MEM_WRITE` for 1 cycle, `PC_EN`=1 in cycle 2, `WRITEENABLE` never 1.
- Opcode `0xFF`:
  - `ILLEGAL`=1 after the edge and stays set through subsequent add instructions.
  - `WRITEENABLE`=0 for the illegal opcode; `PC_EN`=1.
- Reset mid-`MEM_WAIT` with `BUSYWAIT`=1:
  - State returns to `RUN`, no load write pulse, `STALL_CNT`=0.
